// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constant helpers
// Holds the transmit state encoding plus the bit-width and bit-period
// helpers used by both the transmit and receive sides.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Number of bits needed to represent value (0 for value == 0).
    function automatic int logb2(input int value);
        int v;
        int n;
        v = value;
        n = 0;
        while (v > 0) begin
            n = n + 1;
            v = v >>> 1;
        end
        return n;
    endfunction

    // Clock cycles per line bit, truncated.
    function automatic int clks_per_bit(input int clock_in_mhz, input int baud);
        return (clock_in_mhz * 1000000) / baud;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - loadable down-counter marking the end of a bit period
// Ports:
//   i_clk      system clock
//   i_reset    synchronous active-high reset (count -> 0)
//   i_load     restart the period; takes priority over counting
//   i_load_val period length minus one, in cycles
//   o_bit_end  high during the final cycle of the loaded period
module uart_bit_timer #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_bit_end
);

    logic [WIDTH-1:0] r_count;

    // Holds at zero once expired; only a load moves it away from zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_bit_end = (r_count == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmitter: byte handshake in, framed serial bits out
// Ports:
//   clk       system clock
//   reset     synchronous active-high reset
//   tx_valid  tx_data is valid
//   tx_data   byte to send
//   tx_ready  a byte can be accepted
//   tx        serial line, idle high
//   tx_done   one-cycle pulse in the final cycle of the last stop bit
//   busy      frame in progress (~tx_ready)
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int BAUD         = 2400,
    parameter int CLOCK_IN_MHZ = 100,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_done,
    output logic                 busy
);

    localparam int CPB = clks_per_bit(CLOCK_IN_MHZ, BAUD);
    localparam int CW  = logb2(CPB - 1);

    localparam logic [CW-1:0] RELOAD_FULL  = CW'(CPB - 1);
    // The final stop cycle is spent in IDLE with tx_done/tx_ready high, so the
    // STOP state itself covers one cycle less; this lets a back-to-back byte
    // start immediately after the stop bit with no idle gap.
    localparam logic [CW-1:0] RELOAD_SHORT = CW'(CPB - 2);
    localparam logic [CW-1:0] RELOAD_STOP0 = (STOP_BITS == 1) ? RELOAD_SHORT : RELOAD_FULL;
    localparam logic [2:0]    LAST_BIT     = 3'(DATA_BITS - 1);
    localparam logic          LAST_STOP    = 1'(STOP_BITS - 1);

    uart_state_t          r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_tx_ready;
    logic                 r_tx_done;
    logic                 r_busy;

    uart_state_t          w_state_next;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [2:0]           w_bit_idx_next;
    logic                 w_stop_idx_next;
    logic                 w_parity_next;
    logic                 w_tx_next;
    logic                 w_tx_ready_next;
    logic                 w_tx_done_next;
    logic                 w_busy_next;
    logic                 w_load;
    logic [CW-1:0]        w_load_val;
    logic                 w_bit_end;

    uart_bit_timer #(
        .WIDTH(CW)
    ) u_bit_timer (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_bit_end  (w_bit_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
            r_tx_done  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bit_idx  <= w_bit_idx_next;
            r_stop_idx <= w_stop_idx_next;
            r_parity   <= w_parity_next;
            r_tx       <= w_tx_next;
            r_tx_ready <= w_tx_ready_next;
            r_tx_done  <= w_tx_done_next;
            r_busy     <= w_busy_next;
        end
    end

    // Outputs are registered: every branch computes the line level and
    // handshake flags for the cycle after the edge.
    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bit_idx_next  = r_bit_idx;
        w_stop_idx_next = r_stop_idx;
        w_parity_next   = r_parity;
        w_tx_next       = r_tx;
        w_tx_ready_next = r_tx_ready;
        w_tx_done_next  = 1'b0;
        w_busy_next     = r_busy;
        w_load          = 1'b0;
        w_load_val      = RELOAD_FULL;

        unique case (r_state)
            IDLE: begin
                w_tx_next       = 1'b1;
                w_tx_ready_next = 1'b1;
                w_busy_next     = 1'b0;
                if (tx_valid && r_tx_ready) begin
                    w_shift_next    = tx_data;
                    w_parity_next   = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
                    w_state_next    = START;
                    w_tx_next       = 1'b0;
                    w_tx_ready_next = 1'b0;
                    w_busy_next     = 1'b1;
                    w_load          = 1'b1;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next   = DATA;
                    w_bit_idx_next = '0;
                    w_tx_next      = r_shift[0];
                    w_load         = 1'b1;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_next = {1'b0, r_shift[DATA_BITS-1:1]};
                    w_load       = 1'b1;
                    if (r_bit_idx == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            w_state_next = PARITY;
                            w_tx_next    = r_parity;
                        end else begin
                            w_state_next    = STOP;
                            w_tx_next       = 1'b1;
                            w_stop_idx_next = 1'b0;
                            w_load_val      = RELOAD_STOP0;
                        end
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                        w_tx_next      = r_shift[1];
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_next    = STOP;
                    w_tx_next       = 1'b1;
                    w_stop_idx_next = 1'b0;
                    w_load          = 1'b1;
                    w_load_val      = RELOAD_STOP0;
                end
            end
            STOP: begin
                w_tx_next = 1'b1;
                if (w_bit_end) begin
                    if (r_stop_idx == LAST_STOP) begin
                        w_state_next    = IDLE;
                        w_tx_done_next  = 1'b1;
                        w_tx_ready_next = 1'b1;
                        w_busy_next     = 1'b0;
                    end else begin
                        w_stop_idx_next = 1'b1;
                        w_load          = 1'b1;
                        w_load_val      = RELOAD_SHORT;
                    end
                end
            end
            default: begin
                w_state_next    = IDLE;
                w_tx_next       = 1'b1;
                w_tx_ready_next = 1'b1;
                w_busy_next     = 1'b0;
            end
        endcase
    end

    assign tx       = r_tx;
    assign tx_ready = r_tx_ready;
    assign tx_done  = r_tx_done;
    assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk;
    logic       reset;
    logic       tx_valid_a [4];
    logic [7:0] tx_data_a  [4];
    logic       tx_ready_a [4];
    logic       tx_a       [4];
    logic       tx_done_a  [4];
    logic       busy_a     [4];

    int par_en  [4] = '{0, 1, 1, 0};
    int par_odd [4] = '{0, 0, 1, 0};
    int stop_n  [4] = '{1, 1, 1, 2};

    int checks   = 0;
    int failures = 0;

    uart_tx_serializer #(.BAUD(250000), .CLOCK_IN_MHZ(1), .DATA_BITS(8),
        .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid_a[0]), .tx_data(tx_data_a[0]),
        .tx_ready(tx_ready_a[0]), .tx(tx_a[0]), .tx_done(tx_done_a[0]), .busy(busy_a[0]));

    uart_tx_serializer #(.BAUD(250000), .CLOCK_IN_MHZ(1), .DATA_BITS(8),
        .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid_a[1]), .tx_data(tx_data_a[1]),
        .tx_ready(tx_ready_a[1]), .tx(tx_a[1]), .tx_done(tx_done_a[1]), .busy(busy_a[1]));

    uart_tx_serializer #(.BAUD(250000), .CLOCK_IN_MHZ(1), .DATA_BITS(8),
        .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid_a[2]), .tx_data(tx_data_a[2]),
        .tx_ready(tx_ready_a[2]), .tx(tx_a[2]), .tx_done(tx_done_a[2]), .busy(busy_a[2]));

    uart_tx_serializer #(.BAUD(250000), .CLOCK_IN_MHZ(1), .DATA_BITS(8),
        .STOP_BITS(2), .PARITY_EN(0), .PARITY_ODD(0)) u_dut3 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid_a[3]), .tx_data(tx_data_a[3]),
        .tx_ready(tx_ready_a[3]), .tx(tx_a[3]), .tx_done(tx_done_a[3]), .busy(busy_a[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int frame_len(input int k);
        return CPB * (1 + 8 + par_en[k] + stop_n[k]);
    endfunction

    // Line level expected in cycle c (1-based, counted from acceptance).
    function automatic logic exp_tx(input int k, input logic [7:0] d, input int c);
        int   b;
        logic p;
        b = (c - 1) / CPB;
        p = (($countones(d) % 2) == 1) ^ (par_odd[k] == 1);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (par_en[k] == 1 && b == 9) return p;
        return 1'b1;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("idle_tx_i%0d", k), tx_a[k], 1'b1);
                chk($sformatf("idle_done_i%0d", k), tx_done_a[k], 1'b0);
                chk($sformatf("idle_ready_i%0d", k), tx_ready_a[k], 1'b1);
            end
        end
    endtask

    // Starts at a negedge where the instance is expected ready; returns at the
    // negedge of the tx_done cycle so a following call chains back-to-back.
    task automatic frame(input int k, input logic [7:0] d, input int glitch, input int abort);
        int L;
        L = frame_len(k);
        chk($sformatf("accept_ready_i%0d", k), tx_ready_a[k], 1'b1);
        tx_valid_a[k] = 1'b1;
        tx_data_a[k]  = d;
        @(negedge clk);
        tx_valid_a[k] = 1'b0;
        tx_data_a[k]  = 8'($urandom);
        for (int c = 1; c <= L; c++) begin
            if (glitch > 0 && c == glitch) begin
                tx_valid_a[k] = 1'b1;
                tx_data_a[k]  = 8'h12;
            end else if (glitch > 0 && c == glitch + 1) begin
                tx_valid_a[k] = 1'b0;
            end
            chk($sformatf("tx_i%0d_d%02h_c%0d", k, d, c), tx_a[k], exp_tx(k, d, c));
            chk($sformatf("done_i%0d_c%0d", k, c), tx_done_a[k], (c == L));
            chk($sformatf("ready_i%0d_c%0d", k, c), tx_ready_a[k], (c == L));
            chk($sformatf("busy_i%0d_c%0d", k, c), busy_a[k], (c != L));
            if (c == abort) begin
                reset = 1'b1;
                @(negedge clk);
                chk("abort_tx", tx_a[k], 1'b1);
                chk("abort_ready", tx_ready_a[k], 1'b1);
                chk("abort_busy", busy_a[k], 1'b0);
                chk("abort_done", tx_done_a[k], 1'b0);
                reset = 1'b0;
                return;
            end
            if (c < L) @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tx_valid_a[k] = 1'b0;
            tx_data_a[k]  = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_tx_i%0d", k), tx_a[k], 1'b1);
            chk($sformatf("rst_ready_i%0d", k), tx_ready_a[k], 1'b1);
            chk($sformatf("rst_busy_i%0d", k), busy_a[k], 1'b0);
            chk($sformatf("rst_done_i%0d", k), tx_done_a[k], 1'b0);
        end
        reset = 1'b0;

        // 8N1 0xA5, then idle
        frame(0, 8'hA5, 0, 0);
        idle(2);

        // back-to-back 0x00 then 0xFF: second acceptance in the done cycle
        frame(0, 8'h00, 0, 0);
        frame(0, 8'hFF, 0, 0);
        idle(2);

        // parity variants and two stop bits
        frame(1, 8'h07, 0, 0);
        idle(1);
        frame(2, 8'h07, 0, 0);
        idle(1);
        frame(3, 8'h3C, 0, 0);
        idle(1);

        // reset at cycle 15 of a 0x55 frame, no tx_done afterwards
        frame(0, 8'h55, 0, 15);
        idle(45);
        frame(0, 8'h96, 0, 0);
        idle(1);

        // 0x12 pulsed while busy is ignored
        frame(0, 8'hC3, 10, 0);
        idle(1);

        // simultaneous reset and tx_valid: reset wins
        reset         = 1'b1;
        tx_valid_a[0] = 1'b1;
        tx_data_a[0]  = 8'h99;
        @(negedge clk);
        chk("rstvalid_tx", tx_a[0], 1'b1);
        chk("rstvalid_ready", tx_ready_a[0], 1'b1);
        chk("rstvalid_busy", busy_a[0], 1'b0);
        reset         = 1'b0;
        tx_valid_a[0] = 1'b0;
        idle(2);

        // randomized bytes on every configuration, sometimes chained
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) begin
                frame(k, 8'($urandom), 0, 0);
                if ($urandom_range(0, 1) == 1) frame(k, 8'($urandom), 0, 0);
                idle(1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
